// File: rtl/fu_muldiv_iter_if.sv
// fu_muldiv_iter_if: issue / result handshake bundle for the iterative
// multiply/divide functional unit.
//   Issue side : prv_valid, prv_ready, op, rs1_v, rs2_v, pd_in, rob_in
//   Result side: nxt_valid, nxt_ready, res_data, res_pd, res_rob
// master = issuer / CDB arbiter side, slave = functional unit side.
interface fu_muldiv_iter_if #(
    parameter int XLEN      = 32,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
);
    logic                 prv_valid;
    logic                 prv_ready;
    logic [2:0]           op;
    logic [XLEN-1:0]      rs1_v;
    logic [XLEN-1:0]      rs2_v;
    logic [PRF_IDX_W-1:0] pd_in;
    logic [ROB_IDX_W-1:0] rob_in;
    logic                 nxt_valid;
    logic                 nxt_ready;
    logic [XLEN-1:0]      res_data;
    logic [PRF_IDX_W-1:0] res_pd;
    logic [ROB_IDX_W-1:0] res_rob;

    modport master (
        output prv_valid, op, rs1_v, rs2_v, pd_in, rob_in, nxt_ready,
        input  prv_ready, nxt_valid, res_data, res_pd, res_rob
    );

    modport slave (
        input  prv_valid, op, rs1_v, rs2_v, pd_in, rob_in, nxt_ready,
        output prv_ready, nxt_valid, res_data, res_pd, res_rob
    );
endinterface

// File: rtl/fu_muldiv_iter.sv
// fu_muldiv_iter: RV M-extension functional unit (MUL/MULH/MULHSU/MULHU/
// DIV/DIVU/REM/REMU) with a fixed-latency multiplier, a radix-2 restoring
// divider and a single-entry result register. One op in flight; the PRF tag
// and ROB index travel with the op.
// Ports:
//   clk   - clock, all state on the rising edge
//   rst   - asynchronous active-high reset
//   flush - synchronous flush, kills the in-flight op and any pending result
//   bus   - fu_muldiv_iter_if.slave (issue handshake + result handshake)
// Optional: define MULDIV_DIV_FAST_EN to let divide-by-zero, signed
// overflow and unsigned dividend<divisor finish one cycle after accept.
module fu_muldiv_iter #(
    parameter int XLEN      = 32,
    parameter int MUL_CYC   = 3,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    fu_muldiv_iter_if.slave    bus
);

    localparam int CNT_MAX = (XLEN > MUL_CYC) ? XLEN : MUL_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state, state_nxt, start_state;
    logic                 accept;
    logic                 direct_done;

    logic [1:0]           op_q;
    logic [XLEN-1:0]      a_q, b_q;
    logic [PRF_IDX_W-1:0] pd_q;
    logic [ROB_IDX_W-1:0] rob_q;
    logic [CNT_W-1:0]     cnt;

    logic [XLEN-1:0]      rem_q, quo_q, dvs_q;
    logic                 neg_q, neg_r;

    logic [XLEN-1:0]      res_data_q;
    logic [PRF_IDX_W-1:0] res_pd_q;
    logic [ROB_IDX_W-1:0] res_rob_q;

    logic                 sgn_div, a_neg, b_neg;
    logic                 div_fast;
    logic [XLEN-1:0]      fast_res;

    logic [XLEN:0]        rem_sh, diff;
    logic                 qbit;
    logic [XLEN-1:0]      rem_nx, quo_nx, div_res;

    // Product slice for funct3[1:0]: 00 low half, 01 s*s, 10 s*u, 11 u*u.
    // Operands are extended to 2*XLEN so a plain multiply yields the
    // correct low 2*XLEN product bits for any signedness mix.
    function automatic logic [XLEN-1:0] mul_res(input logic [1:0]      f,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic                sa, sb;
        logic [2*XLEN-1:0]   ea, eb, p;
        sa = (f == 2'b01 || f == 2'b10) && a[XLEN-1];
        sb = (f == 2'b01) && b[XLEN-1];
        ea = {{XLEN{sa}}, a};
        eb = {{XLEN{sb}}, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic neg, input logic [XLEN-1:0] x);
        return neg ? ('0 - x) : x;
    endfunction

    // ---------------- handshake ----------------
    assign bus.prv_ready = (state == IDLE) || (state == DONE && bus.nxt_ready);
    assign accept        = bus.prv_valid && bus.prv_ready && !flush;
    assign bus.nxt_valid = (state == DONE);
    assign bus.res_data  = res_data_q;
    assign bus.res_pd    = res_pd_q;
    assign bus.res_rob   = res_rob_q;

    assign sgn_div = !bus.op[0];
    assign a_neg   = sgn_div && bus.rs1_v[XLEN-1];
    assign b_neg   = sgn_div && bus.rs2_v[XLEN-1];

`ifdef MULDIV_DIV_FAST_EN
    logic fz, fovf, fult;
    assign fz       = (bus.rs2_v == '0);
    assign fovf     = sgn_div && (bus.rs1_v == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_v == '1);
    assign fult     = !sgn_div && (bus.rs1_v < bus.rs2_v);
    assign div_fast = bus.op[2] && (fz || fovf || fult);
    // quotient: '1 on zero divisor, dividend on overflow, 0 when a<b;
    // remainder: 0 on overflow, otherwise the dividend itself.
    assign fast_res = bus.op[1] ? (fovf ? '0 : bus.rs1_v)
                                : (fz ? '1 : (fovf ? bus.rs1_v : '0));
`else
    assign div_fast = 1'b0;
    assign fast_res = '0;
`endif

    assign direct_done = bus.op[2] ? div_fast : (MUL_CYC == 1);

    always_comb begin
        start_state = DIV;
        if (!bus.op[2])
            start_state = (MUL_CYC == 1) ? DONE : MUL;
        else if (div_fast)
            start_state = DONE;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = start_state;
            MUL:  if (cnt == '0) state_nxt = DONE;
            DIV:  if (cnt == '0) state_nxt = DONE;
            DONE: if (bus.nxt_ready) state_nxt = accept ? start_state : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // ---------------- divider step ----------------
    always_comb begin
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        diff    = rem_sh - {1'b0, dvs_q};
        qbit    = !diff[XLEN];
        rem_nx  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], qbit};
        // A zero divisor leaves every quotient bit set and neg_q cleared,
        // so the all-ones quotient falls out without a special case.
        div_res = op_q[1] ? mag(neg_r, rem_nx) : mag(neg_q, quo_nx);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pd_q       <= '0;
            rob_q      <= '0;
            cnt        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            res_data_q <= '0;
            res_pd_q   <= '0;
            res_rob_q  <= '0;
        end else if (!flush) begin
            if (accept) begin
                op_q  <= bus.op[1:0];
                a_q   <= bus.rs1_v;
                b_q   <= bus.rs2_v;
                pd_q  <= bus.pd_in;
                rob_q <= bus.rob_in;
                // The accept edge itself is the first multiply cycle, so the
                // counter starts one lower to land nxt_valid in cycle MUL_CYC.
                cnt   <= bus.op[2] ? CNT_W'(XLEN - 1)
                                   : CNT_W'((MUL_CYC > 1) ? MUL_CYC - 2 : 0);
                rem_q <= '0;
                quo_q <= mag(a_neg, bus.rs1_v);
                dvs_q <= mag(b_neg, bus.rs2_v);
                neg_q <= (a_neg ^ b_neg) && (bus.rs2_v != '0);
                neg_r <= a_neg;
                if (direct_done) begin
                    res_data_q <= bus.op[2] ? fast_res
                                            : mul_res(bus.op[1:0], bus.rs1_v, bus.rs2_v);
                    res_pd_q   <= bus.pd_in;
                    res_rob_q  <= bus.rob_in;
                end
            end else begin
                unique case (state)
                    MUL: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            res_data_q <= mul_res(op_q, a_q, b_q);
                            res_pd_q   <= pd_q;
                            res_rob_q  <= rob_q;
                        end
                    end
                    DIV: begin
                        cnt   <= cnt - 1'b1;
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        if (cnt == '0) begin
                            res_data_q <= div_res;
                            res_pd_q   <= pd_q;
                            res_rob_q  <= rob_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fu_muldiv_iter.sv
module tb_fu_muldiv_iter;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = 33;
`ifdef MULDIV_DIV_FAST_EN
    localparam int LAT_SPL = 1;
`else
    localparam int LAT_SPL = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;
    int   seen;

    always #5 clk = ~clk;

    fu_muldiv_iter_if #(.XLEN(32), .PRF_IDX_W(6), .ROB_IDX_W(5)) bus ();

    fu_muldiv_iter #(.XLEN(32), .MUL_CYC(3), .PRF_IDX_W(6), .ROB_IDX_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; accept happens on the following posedge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] pd, input logic [4:0] rob);
        bus.op        = f;
        bus.rs1_v     = a;
        bus.rs2_v     = b;
        bus.pd_in     = pd;
        bus.rob_in    = rob;
        bus.prv_valid = 1'b1;
        #1;
        chk("prv_ready_at_issue", {63'd0, bus.prv_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.prv_valid = 1'b0;
        bus.rs1_v     = '1;
        bus.rs2_v     = '1;
        cyc           = 1;
    endtask

    task automatic wait_valid(input string tag, input int lat);
        while (bus.nxt_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp,
                          input logic [5:0] pd, input logic [4:0] rob);
        issue(f, a, b, pd, rob);
        wait_valid(tag, lat);
        chk({tag, "_data"}, {32'd0, bus.res_data}, {32'd0, exp});
        chk({tag, "_pd"},   {58'd0, bus.res_pd},   {58'd0, pd});
        chk({tag, "_rob"},  {59'd0, bus.res_rob},  {59'd0, rob});
        @(negedge clk);
        chk({tag, "_retired"}, {63'd0, bus.nxt_valid}, 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.prv_valid = 1'b0;
        bus.op        = '0;
        bus.rs1_v     = '0;
        bus.rs2_v     = '0;
        bus.pd_in     = '0;
        bus.rob_in    = '0;
        bus.nxt_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_nxt_valid", {63'd0, bus.nxt_valid}, 64'd0);
        chk("reset_res_data",  {32'd0, bus.res_data},  64'd0);
        chk("reset_res_pd",    {58'd0, bus.res_pd},    64'd0);
        chk("reset_res_rob",   {59'd0, bus.res_rob},   64'd0);
        chk("reset_prv_ready", {63'd0, bus.prv_ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // multiply
        run_op("mulh_m1x2",     OP_MULH,   32'hFFFFFFFF, 32'h00000002, LAT_MUL, 32'hFFFFFFFF, 6'd1, 5'd1);
        run_op("mul_m1x2",      OP_MUL,    32'hFFFFFFFF, 32'h00000002, LAT_MUL, 32'hFFFFFFFE, 6'd2, 5'd2);
        run_op("mulhsu_m1x2",   OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, LAT_MUL, 32'hFFFFFFFF, 6'd3, 5'd3);
        run_op("mulhsu_min",    OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, LAT_MUL, 32'h80000000, 6'd4, 5'd4);
        run_op("mulhu_min",     OP_MULHU,  32'h80000000, 32'hFFFFFFFF, LAT_MUL, 32'h7FFFFFFF, 6'd5, 5'd5);

        // divide
        run_op("div_m7_2",      OP_DIV,    32'hFFFFFFF9, 32'd2,        LAT_DIV, 32'hFFFFFFFD, 6'd6, 5'd6);
        run_op("rem_m7_2",      OP_REM,    32'hFFFFFFF9, 32'd2,        LAT_DIV, 32'hFFFFFFFF, 6'd7, 5'd7);
        run_op("remu_7_3",      OP_REMU,   32'd7,        32'd3,        LAT_DIV, 32'd1,        6'd8, 5'd8);
        run_op("divu_7_3",      OP_DIVU,   32'd7,        32'd3,        LAT_DIV, 32'd2,        6'd9, 5'd9);
        run_op("div_7_m2",      OP_DIV,    32'd7,        32'hFFFFFFFE, LAT_DIV, 32'hFFFFFFFD, 6'd10, 5'd10);
        run_op("rem_7_m2",      OP_REM,    32'd7,        32'hFFFFFFFE, LAT_DIV, 32'd1,        6'd11, 5'd11);

        // special cases
        run_op("divu_5_0",      OP_DIVU,   32'd5,        32'd0,        LAT_SPL, 32'hFFFFFFFF, 6'd12, 5'd12);
        run_op("rem_5_0",       OP_REM,    32'd5,        32'd0,        LAT_SPL, 32'd5,        6'd13, 5'd13);
        run_op("div_m5_0",      OP_DIV,    32'hFFFFFFFB, 32'd0,        LAT_SPL, 32'hFFFFFFFF, 6'd14, 5'd14);
        run_op("rem_m5_0",      OP_REM,    32'hFFFFFFFB, 32'd0,        LAT_SPL, 32'hFFFFFFFB, 6'd15, 5'd15);
        run_op("div_ovf",       OP_DIV,    32'h80000000, 32'hFFFFFFFF, LAT_SPL, 32'h80000000, 6'd16, 5'd16);
        run_op("rem_ovf",       OP_REM,    32'h80000000, 32'hFFFFFFFF, LAT_SPL, 32'd0,        6'd17, 5'd17);
        run_op("divu_3_7",      OP_DIVU,   32'd3,        32'd7,        LAT_SPL, 32'd0,        6'd18, 5'd18);
        run_op("remu_3_7",      OP_REMU,   32'd3,        32'd7,        LAT_SPL, 32'd3,        6'd19, 5'd19);

        // backpressure, then same-edge retire + accept
        bus.nxt_ready = 1'b0;
        issue(OP_MUL, 32'd6, 32'd7, 6'd20, 5'd20);
        wait_valid("bp_first", LAT_MUL);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", {63'd0, bus.nxt_valid}, 64'd1);
            chk("bp_data_held",  {32'd0, bus.res_data},  64'd42);
            chk("bp_pd_held",    {58'd0, bus.res_pd},    64'd20);
            chk("bp_rob_held",   {59'd0, bus.res_rob},   64'd20);
            chk("bp_prv_ready",  {63'd0, bus.prv_ready}, 64'd0);
        end
        bus.nxt_ready = 1'b1;
        issue(OP_MUL, 32'd3, 32'd4, 6'd33, 5'd21);
        chk("b2b_old_retired", {63'd0, bus.nxt_valid}, 64'd0);
        wait_valid("b2b_second", LAT_MUL);
        chk("b2b_data", {32'd0, bus.res_data}, 64'd12);
        chk("b2b_pd",   {58'd0, bus.res_pd},   64'd33);
        chk("b2b_rob",  {59'd0, bus.res_rob},  64'd21);
        @(negedge clk);

        // flush mid-divide in cycle 10
        issue(OP_DIV, 32'd100, 32'd7, 6'd22, 5'd22);
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_prv_ready", {63'd0, bus.prv_ready}, 64'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.nxt_valid === 1'b1) seen++;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        run_op("mulhu_after_flush", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL, 32'hFFFFFFFE, 6'd23, 5'd23);

        // flush in DONE with nxt_ready and a competing accept: both dropped
        bus.nxt_ready = 1'b0;
        issue(OP_MUL, 32'd2, 32'd3, 6'd24, 5'd24);
        wait_valid("flush_done_op", LAT_MUL);
        flush         = 1'b1;
        bus.nxt_ready = 1'b1;
        bus.op        = OP_MUL;
        bus.rs1_v     = 32'd5;
        bus.rs2_v     = 32'd5;
        bus.prv_valid = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        bus.prv_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.nxt_valid === 1'b1) seen++;
            @(negedge clk);
        end
        chk("flush_done_dropped", 64'(seen), 64'd0);

        // async reset pulse between edges during a multiply
        issue(OP_MUL, 32'd6, 32'd7, 6'd25, 5'd25);
        #2 rst = 1'b1;
        #1;
        chk("arst_nxt_valid", {63'd0, bus.nxt_valid}, 64'd0);
        chk("arst_res_data",  {32'd0, bus.res_data},  64'd0);
        chk("arst_res_pd",    {58'd0, bus.res_pd},    64'd0);
        chk("arst_res_rob",   {59'd0, bus.res_rob},   64'd0);
        #1 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.nxt_valid === 1'b1) seen++;
        end
        chk("arst_no_stale", 64'(seen), 64'd0);
        run_op("mul_after_reset", OP_MUL, 32'd3, 32'd4, LAT_MUL, 32'd12, 6'd26, 5'd26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
